mem_responder: RTL and testbench
================================

Name: mem_responder

Overview:
- Memory-side responder that services load/store requests from the multicycle RISC-V core over a valid/ready request/response handshake.
- Replaces the zero-latency combinational memory with a word-addressed RAM that has a configurable number of wait states.
- One outstanding transaction at a time; the core's control FSM stalls on resp_valid.

Parameters:
- DEPTH, 1024, number of 32-bit words in the array.
- LATENCY, 2, wait cycles inserted before the array access (legal range 0..15).
- BASE_ADDR, 32'h0000_0000, byte address mapped to word 0.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request.
- req_we  input  1  1 = store, 0 = load.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data.
- resp_valid  output  1  response present.
- resp_ready  input  1  requester accepts the response.
- resp_rdata  output  32  load data; 0 for stores and errors.
- resp_err  output  1  misaligned or out-of-range access.
- busy  output  1  state != IDLE.

Behaviour:
- Reset: rst==0 at a posedge forces state=IDLE, cnt=0, resp_valid=0, resp_rdata=0, resp_err=0, and clears the latched request. Array contents are not reset. Reset overrides every other event in the same cycle.
- FSM has three states: IDLE, WAIT, RESP.
- req_ready = (state==IDLE), combinational from state. busy = !req_ready.
- IDLE:
  - req_valid && req_ready at a posedge latches req_addr, req_we and req_wdata, loads cnt<=LATENCY, and moves to WAIT.
  - Request inputs are ignored in all other states.
- WAIT:
  - If cnt!=0, decrement cnt.
  - If cnt==0, perform the access at this edge, register the response, set resp_valid<=1, and move to RESP.
- Response timing: for acceptance at edge k, resp_valid is first high after edge k+1+LATENCY.
- Access rules:
  - idx = (addr - BASE_ADDR) >> 2.
  - Error when addr[1:0]!=0, addr < BASE_ADDR, or idx >= DEPTH. On error: no array read or write, resp_err=1, resp_rdata=0. Latency is unchanged.
  - Store: mem[idx] <= wdata, resp_rdata=0, resp_err=0.
  - Load: resp_rdata = mem[idx], resp_err=0.
  - A load after a completed store to the same address returns the new data.
- RESP:
  - resp_valid, resp_rdata and resp_err are held stable until resp_valid && resp_ready at a posedge.
  - On that edge: resp_valid<=0, resp_err<=0, resp_rdata<=0, state goes to IDLE.
  - The next request can be accepted no earlier than the following edge.
- Throughput: one transaction per LATENCY+3 cycles when resp_ready is held at 1.
- Reset mid-operation:
  - Reset in WAIT before the access edge: no write occurs.
  - Reset in RESP: the write has already been committed; the response is dropped.
- Memory is synchronous-write, registered-read; no combinational path from req_* to resp_*.

Test Plan:
- Reset: hold rst=0 for 2 cycles with random inputs -> req_ready=1, busy=0, resp_valid=0, resp_rdata=32'h0, resp_err=0.
- Store then load (LATENCY=2):
  - Store 0xDEADBEEF to 0x10, accepted at edge k -> resp_valid rises after edge k+3, resp_err=0, resp_rdata=0.
  - Load 0x10 -> resp_rdata=0xDEADBEEF three edges after its acceptance.
- Backpressure: hold resp_ready=0 for 5 cycles during a load of 0x10 -> resp_valid, resp_rdata and resp_err are stable and req_ready=0; a second req_valid pulse is ignored, and exactly one response is seen after resp_ready=1.
- Errors:
  - Store to 0x12 -> resp_err=1, resp_rdata=0; a later load of 0x10 still returns 0xDEADBEEF.
  - Load of 0x1000 (DEPTH=1024) -> resp_err=1.
- Reset mid-WAIT: store 0x12345678 to 0x20, assert rst=0 at edge k+1 -> IDLE at the next edge; a later load of 0x20 returns its prior value.
- LATENCY=0 instance with resp_ready=1: back-to-back loads -> accepts at edges k and k+3, with responses after edges k+1 and k+4.

Source files
------------

// File: rtl/mem_responder.sv
// Word-addressed RAM responder with configurable wait states behind a valid/ready
// request/response handshake; one transaction in flight at a time.
module mem_responder #(
    parameter int unsigned DEPTH     = 1024,
    parameter int unsigned LATENCY   = 2,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        busy
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        we_q, we_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        resp_err_q, resp_err_d;

    logic [31:0] mem [DEPTH];

    logic [31:0] offset;
    logic [31:0] idx_full;
    logic [AW-1:0] mem_idx;
    logic        access_err;
    logic        mem_we;

    // Address decode works on the latched request, never on req_* directly.
    assign offset     = addr_q - BASE_ADDR;
    assign idx_full   = offset >> 2;
    assign mem_idx    = idx_full[AW-1:0];
    assign access_err = (addr_q[1:0] != 2'b00) || (addr_q < BASE_ADDR) || (idx_full >= DEPTH);

    assign req_ready  = (state_q == StIdle);
    assign busy       = !req_ready;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        we_d         = we_q;
        resp_valid_d = resp_valid_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        mem_we       = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    we_d    = req_we;
                    cnt_d   = 4'(LATENCY);
                    state_d = StWait;
                end
            end
            StWait: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    mem_we       = we_q && !access_err;
                    resp_valid_d = 1'b1;
                    resp_err_d   = access_err;
                    resp_rdata_d = (access_err || we_q) ? 32'h0 : mem[mem_idx];
                    state_d      = StResp;
                end
            end
            StResp: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    resp_err_d   = 1'b0;
                    resp_rdata_d = 32'h0;
                    state_d      = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= StIdle;
            cnt_q        <= 4'd0;
            addr_q       <= 32'h0;
            wdata_q      <= 32'h0;
            we_q         <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'h0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            we_q         <= we_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    // Array is not reset, but a reset edge still suppresses a pending write.
    always_ff @(posedge clk) begin
        if (rst && mem_we) begin
            mem[mem_idx] <= wdata_q;
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: vector table, directed corner sequences and
// randomized traffic against a word-array reference model.
module tb_mem_responder;

    localparam int unsigned DEPTH = 1024;
    localparam int unsigned LAT   = 2;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0, req_we = 1'b0, resp_ready = 1'b0;
    logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
    logic        req_ready, resp_valid, resp_err, busy;
    logic [31:0] resp_rdata;

    logic        req_valid0 = 1'b0, req_we0 = 1'b0, resp_ready0 = 1'b1;
    logic [31:0] req_addr0 = 32'h0, req_wdata0 = 32'h0;
    logic        req_ready0, resp_valid0, resp_err0, busy0;
    logic [31:0] resp_rdata0;

    int checks = 0;
    int errors = 0;

    logic [31:0] model_mem [DEPTH];

    always #5 clk = ~clk;

    mem_responder #(.DEPTH(DEPTH), .LATENCY(LAT), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err), .busy(busy)
    );

    mem_responder #(.DEPTH(DEPTH), .LATENCY(0), .BASE_ADDR(BASE)) dut0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid0), .req_ready(req_ready0), .req_we(req_we0),
        .req_addr(req_addr0), .req_wdata(req_wdata0),
        .resp_valid(resp_valid0), .resp_ready(resp_ready0),
        .resp_rdata(resp_rdata0), .resp_err(resp_err0), .busy(busy0)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void model_access(input logic we, input logic [31:0] addr,
                                         input logic [31:0] wdata,
                                         output logic [31:0] rdata, output logic err);
        int unsigned i;
        err   = (addr % 4 != 0) || (addr < BASE) || (((addr - BASE) / 4) >= DEPTH);
        rdata = 32'h0;
        if (!err) begin
            i = (addr - BASE) / 4;
            if (we) model_mem[i] = wdata;
            else    rdata = model_mem[i];
        end
    endfunction

    // Issue one request from idle, check latency, hold the response for `hold` cycles.
    task automatic do_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input int hold, input logic [31:0] exp_rdata, input logic exp_err);
        int n;
        check("req_ready_idle", {31'h0, req_ready}, 32'h1);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
        @(posedge clk); #1;
        req_valid = 1'b0; req_we = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
        check("busy_after_accept", {31'h0, busy}, 32'h1);
        n = 0;
        while (!resp_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check("latency", n, LAT + 1);
        check("rdata", resp_rdata, exp_rdata);
        check("err", {31'h0, resp_err}, {31'h0, exp_err});
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("hold_valid", {31'h0, resp_valid}, 32'h1);
            check("hold_rdata", resp_rdata, exp_rdata);
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        check("resp_cleared", {31'h0, resp_valid}, 32'h0);
        check("idle_again", {31'h0, req_ready}, 32'h1);
    endtask

    task automatic store0(input logic [31:0] addr, input logic [31:0] data);
        req_valid0 = 1'b1; req_we0 = 1'b1; req_addr0 = addr; req_wdata0 = data;
        @(posedge clk); #1;
        req_valid0 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("lat0_store_idle", {31'h0, req_ready0}, 32'h1);
    endtask

    vec_t        vecs [10];
    logic [31:0] m_rd;
    logic        m_err;

    initial begin
        vecs[0] = '{1'b1, 32'h10,   32'hDEAD_BEEF, 32'h0,         1'b0};
        vecs[1] = '{1'b0, 32'h10,   32'h0,         32'hDEAD_BEEF, 1'b0};
        vecs[2] = '{1'b1, 32'h12,   32'hCAFE_F00D, 32'h0,         1'b1};
        vecs[3] = '{1'b0, 32'h10,   32'h0,         32'hDEAD_BEEF, 1'b0};
        vecs[4] = '{1'b0, 32'h1000, 32'h0,         32'h0,         1'b1};
        vecs[5] = '{1'b1, 32'hFFC,  32'h1357_2468, 32'h0,         1'b0};
        vecs[6] = '{1'b0, 32'hFFC,  32'h0,         32'h1357_2468, 1'b0};
        vecs[7] = '{1'b1, 32'h20,   32'h0BAD_F00D, 32'h0,         1'b0};
        vecs[8] = '{1'b0, 32'h11,   32'h0,         32'h0,         1'b1};
        vecs[9] = '{1'b1, 32'h1004, 32'h1111_1111, 32'h0,         1'b1};

        // Reset with random inputs toggling.
        rst = 1'b0;
        repeat (2) begin
            req_valid = 1'($urandom); req_we = 1'($urandom); req_addr = $urandom;
            req_wdata = $urandom; resp_ready = 1'($urandom);
            @(posedge clk); #1;
        end
        check("rst_req_ready", {31'h0, req_ready}, 32'h1);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
        check("rst_resp_rdata", resp_rdata, 32'h0);
        check("rst_resp_err", {31'h0, resp_err}, 32'h0);
        req_valid = 1'b0; resp_ready = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;

        for (int v = 0; v < 10; v++) begin
            do_txn(vecs[v].we, vecs[v].addr, vecs[v].wdata, 0, vecs[v].exp_rdata, vecs[v].exp_err);
            model_access(vecs[v].we, vecs[v].addr, vecs[v].wdata, m_rd, m_err);
        end

        // Backpressure on a load of 0x10 with a stray request pulse in the middle.
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (LAT + 1) @(posedge clk);
        #1;
        for (int c = 0; c < 5; c++) begin
            check("bp_valid", {31'h0, resp_valid}, 32'h1);
            check("bp_rdata", resp_rdata, 32'hDEAD_BEEF);
            check("bp_err", {31'h0, resp_err}, 32'h0);
            check("bp_req_ready", {31'h0, req_ready}, 32'h0);
            req_valid = (c == 2); req_we = 1'b1; req_addr = 32'h10; req_wdata = 32'h5555_5555;
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        for (int c = 0; c < 6; c++) begin
            check("bp_single_resp", {31'h0, resp_valid}, 32'h0);
            @(posedge clk); #1;
        end
        resp_ready = 1'b0;
        do_txn(1'b0, 32'h10, 32'h0, 0, 32'hDEAD_BEEF, 1'b0);

        // Reset during WAIT must drop the store.
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h1234_5678;
        @(posedge clk); #1;
        req_valid = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        check("midwait_req_ready", {31'h0, req_ready}, 32'h1);
        check("midwait_busy", {31'h0, busy}, 32'h0);
        check("midwait_resp_valid", {31'h0, resp_valid}, 32'h0);
        do_txn(1'b0, 32'h20, 32'h0, 0, 32'h0BAD_F00D, 1'b0);

        // LATENCY=0: back-to-back loads with resp_ready held high.
        store0(32'h40, 32'hA5A5_0001);
        store0(32'h44, 32'h5A5A_0002);
        req_valid0 = 1'b1; req_we0 = 1'b0; req_addr0 = 32'h40;
        @(posedge clk); #1;
        check("lat0_k_ready", {31'h0, req_ready0}, 32'h0);
        check("lat0_k_valid", {31'h0, resp_valid0}, 32'h0);
        req_addr0 = 32'h44;
        @(posedge clk); #1;
        check("lat0_k1_valid", {31'h0, resp_valid0}, 32'h1);
        check("lat0_k1_rdata", resp_rdata0, 32'hA5A5_0001);
        @(posedge clk); #1;
        check("lat0_k2_valid", {31'h0, resp_valid0}, 32'h0);
        check("lat0_k2_ready", {31'h0, req_ready0}, 32'h1);
        @(posedge clk); #1;
        req_valid0 = 1'b0;
        check("lat0_k3_ready", {31'h0, req_ready0}, 32'h0);
        @(posedge clk); #1;
        check("lat0_k4_valid", {31'h0, resp_valid0}, 32'h1);
        check("lat0_k4_rdata", resp_rdata0, 32'h5A5A_0002);
        @(posedge clk); #1;
        check("lat0_k5_idle", {31'h0, req_ready0}, 32'h1);

        // Random traffic over a small, fully initialised window plus error addresses.
        for (int i = 0; i < 16; i++) begin
            logic [31:0] d;
            d = $urandom;
            model_access(1'b1, BASE + i * 4, d, m_rd, m_err);
            do_txn(1'b1, BASE + i * 4, d, 0, m_rd, m_err);
        end
        for (int t = 0; t < 150; t++) begin
            int unsigned r;
            logic [31:0] a, d;
            logic        w;
            r = $urandom_range(0, 9);
            a = BASE + $urandom_range(0, 15) * 4;
            if (r == 7)      a = a + $urandom_range(1, 3);
            else if (r >= 8) a = BASE + DEPTH * 4 + $urandom_range(0, 255) * 4;
            w = 1'($urandom);
            d = $urandom;
            model_access(w, a, d, m_rd, m_err);
            do_txn(w, a, d, $urandom_range(0, 3), m_rd, m_err);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
